// File: rtl/prga_decrypt.sv
// RC4 PRGA decryptor: walks a pre-shuffled S memory, XORs the keystream
// with a ciphertext ROM and flags any plaintext byte that is not a-z or space.
module prga_decrypt #(
    parameter int MSG_LENGTH = 32
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       start,
    output logic       done,
    output logic       key_valid,
    output logic [7:0] s_address,
    output logic [7:0] s_data_out,
    output logic       s_wren,
    input  logic [7:0] s_data_in,
    output logic [4:0] rom_address,
    input  logic [7:0] rom_data_in,
    output logic [4:0] dec_address,
    output logic [7:0] dec_data,
    output logic       dec_wren
);

    localparam logic [4:0] LAST_K = 5'(MSG_LENGTH - 1);

    typedef enum logic [3:0] {
        IDLE,
        RD_SI,
        WT_SI,
        RD_SJ,
        WT_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WT_F,
        WR_D,
        DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [4:0] r_k;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [7:0] r_f;
    logic [7:0] r_enc;
    logic       r_invalid;

    logic [7:0] w_sum;
    logic [7:0] w_dec;
    logic       w_dec_ok;
    logic       w_last;

    assign w_sum    = r_si + r_sj;
    assign w_dec    = r_f ^ r_enc;
    assign w_dec_ok = ((w_dec >= 8'h61) && (w_dec <= 8'h7A))
                    || (w_dec == 8'h20);
    assign w_last   = (r_k == LAST_K);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Datapath registers update only in the states that own them.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_i       <= 8'd0;
            r_j       <= 8'd0;
            r_k       <= 5'd0;
            r_si      <= 8'd0;
            r_sj      <= 8'd0;
            r_f       <= 8'd0;
            r_enc     <= 8'd0;
            r_invalid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i       <= 8'd1;
                        r_j       <= 8'd0;
                        r_k       <= 5'd0;
                        r_invalid <= 1'b0;
                    end
                end
                WT_SI: begin
                    r_si <= s_data_in;
                    r_j  <= r_j + s_data_in;
                end
                WT_SJ: begin
                    r_sj <= s_data_in;
                end
                WT_F: begin
                    r_f   <= s_data_in;
                    r_enc <= rom_data_in;
                end
                WR_D: begin
                    if (!w_dec_ok) begin
                        r_invalid <= 1'b1;
                    end
                    if (!w_last) begin
                        r_k <= r_k + 5'd1;
                        r_i <= r_i + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = RD_SI;
            RD_SI:   w_next = WT_SI;
            WT_SI:   w_next = RD_SJ;
            RD_SJ:   w_next = WT_SJ;
            WT_SJ:   w_next = WR_SI;
            WR_SI:   w_next = WR_SJ;
            WR_SJ:   w_next = RD_F;
            RD_F:    w_next = WT_F;
            WT_F:    w_next = WR_D;
            WR_D:    w_next = w_last ? DONE : RD_SI;
            DONE:    if (!start) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Moore outputs; the i==j swap needs no special case since sj==si then.
    always_comb begin
        done        = 1'b0;
        key_valid   = 1'b0;
        s_address   = 8'd0;
        s_data_out  = 8'd0;
        s_wren      = 1'b0;
        rom_address = 5'd0;
        dec_address = 5'd0;
        dec_data    = 8'd0;
        dec_wren    = 1'b0;
        unique case (r_state)
            RD_SI, WT_SI: begin
                s_address = r_i;
            end
            RD_SJ, WT_SJ: begin
                s_address = r_j;
            end
            WR_SI: begin
                s_address  = r_i;
                s_data_out = r_sj;
                s_wren     = 1'b1;
            end
            WR_SJ: begin
                s_address  = r_j;
                s_data_out = r_si;
                s_wren     = 1'b1;
            end
            RD_F, WT_F: begin
                s_address   = w_sum;
                rom_address = r_k;
            end
            WR_D: begin
                dec_address = r_k;
                dec_data    = w_dec;
                dec_wren    = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
                key_valid = !r_invalid;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: memory models around the DUT and an
// array-based RC4 PRGA reference model.
module tb_prga_decrypt;

    localparam int MSG = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic       key_valid;
    logic [7:0] s_address;
    logic [7:0] s_data_out;
    logic       s_wren;
    logic [7:0] s_q;
    logic [4:0] rom_address;
    logic [7:0] rom_q;
    logic [4:0] dec_address;
    logic [7:0] dec_data;
    logic       dec_wren;

    prga_decrypt #(.MSG_LENGTH(MSG)) dut (
        .CLOCK_50   (clk),
        .reset_n    (rst_n),
        .start      (start),
        .done       (done),
        .key_valid  (key_valid),
        .s_address  (s_address),
        .s_data_out (s_data_out),
        .s_wren     (s_wren),
        .s_data_in  (s_q),
        .rom_address(rom_address),
        .rom_data_in(rom_q),
        .dec_address(dec_address),
        .dec_data   (dec_data),
        .dec_wren   (dec_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem   [256];
    logic [7:0] rom_mem [MSG];
    logic [7:0] dec_mem [MSG];
    logic [7:0] s_init  [256];
    logic [7:0] enc_init[MSG];
    logic [7:0] m_s     [256];
    logic [7:0] m_dec   [MSG];
    logic [7:0] ks      [MSG];
    logic       m_ok;
    logic       do_load = 1'b0;
    int         s_wr_cnt = 0;
    int         dec_wr_cnt = 0;
    int         bad_idle = 0;
    int         nchk = 0;
    int         nerr = 0;

    always @(posedge clk) begin
        if (do_load) begin
            s_mem   <= s_init;
            rom_mem <= enc_init;
        end else begin
            if (s_wren) begin
                s_mem[s_address] <= s_data_out;
                s_wr_cnt <= s_wr_cnt + 1;
            end
            if (dec_wren) begin
                dec_mem[dec_address] <= dec_data;
                dec_wr_cnt <= dec_wr_cnt + 1;
            end
        end
        s_q   <= s_mem[s_address];
        rom_q <= rom_mem[rom_address];
    end

    always @(negedge clk) begin
        if ((!s_wren && s_data_out != 8'd0) || (!dec_wren && dec_data != 8'd0))
            bad_idle <= bad_idle + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mems();
        do_load = 1'b1;
        tick();
        do_load = 1'b0;
    endtask

    // Straight RC4 PRGA over copies of s_init / enc_init.
    task automatic model_run();
        int i;
        int j;
        logic [7:0] t;
        i = 0;
        j = 0;
        m_s = s_init;
        m_ok = 1'b1;
        for (int k = 0; k < MSG; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(m_s[i])) % 256;
            t = m_s[i];
            m_s[i] = m_s[j];
            m_s[j] = t;
            m_dec[k] = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256] ^ enc_init[k];
            if (!((m_dec[k] >= 8'h61 && m_dec[k] <= 8'h7A) || m_dec[k] == 8'h20))
                m_ok = 1'b0;
        end
    endtask

    task automatic set_identity();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    task automatic set_random_perm();
        logic [7:0] t;
        int r;
        set_identity();
        for (int x = 255; x > 0; x--) begin
            r = int'($urandom_range(x, 0));
            t = s_init[x];
            s_init[x] = s_init[r];
            s_init[r] = t;
        end
    endtask

    task automatic set_enc_zero();
        for (int k = 0; k < MSG; k++) enc_init[k] = 8'd0;
    endtask

    // Keystream for the current s_init, via the model with zero ciphertext.
    task automatic make_ks();
        set_enc_zero();
        model_run();
        ks = m_dec;
    endtask

    // Pulse (or hold) start and wait for done; cycles==1 in the first RD_SI.
    task automatic run_wait(input bit hold, output int cycles);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        cycles = 1;
        while (!done && cycles < 2000) begin
            tick();
            cycles++;
        end
    endtask

    function automatic int dec_diff();
        int n;
        n = 0;
        for (int k = 0; k < MSG; k++)
            if (dec_mem[k] !== m_dec[k]) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        nchk++;
        if ({done, key_valid, s_address, s_data_out, s_wren, rom_address,
             dec_address, dec_data, dec_wren} !== 40'd0) begin
            nerr++;
            $display("FAIL reset_outputs: got done=%b s_addr=%h wren=%b/%b, want all 0",
                     done, s_address, s_wren, dec_wren);
        end
        rst_n = 1'b1;
        tick();
        nchk++;
        if (done !== 1'b0 || s_address !== 8'd0) begin
            nerr++;
            $display("FAIL idle_after_reset: done=%b s_addr=%h, want 0/00", done, s_address);
        end
    endtask

    task automatic test_identity_zero();
        int cyc;
        int sw0;
        int dw0;
        set_identity();
        set_enc_zero();
        model_run();
        load_mems();
        sw0 = s_wr_cnt;
        dw0 = dec_wr_cnt;
        run_wait(1'b0, cyc);
        nchk++;
        if (dec_mem[0] !== 8'h02 || dec_mem[1] !== 8'h05) begin
            nerr++;
            $display("FAIL ident_dec01: got %h %h, want 02 05", dec_mem[0], dec_mem[1]);
        end
        nchk++;
        if (dec_diff() != 0) begin
            nerr++;
            $display("FAIL ident_model: %0d bytes differ from model", dec_diff());
        end
        nchk++;
        if (s_mem !== m_s) begin
            nerr++;
            $display("FAIL ident_sfinal: S[2]=%h S[3]=%h, want %h %h",
                     s_mem[2], s_mem[3], m_s[2], m_s[3]);
        end
        nchk++;
        if (key_valid !== 1'b0) begin
            nerr++;
            $display("FAIL ident_keyvalid: got %b, want 0", key_valid);
        end
        nchk++;
        if (cyc != 9 * MSG + 1) begin
            nerr++;
            $display("FAIL ident_latency: got %0d, want %0d", cyc, 9 * MSG + 1);
        end
        nchk++;
        if (s_wr_cnt - sw0 != 2 * MSG || dec_wr_cnt - dw0 != MSG) begin
            nerr++;
            $display("FAIL ident_writes: got s=%0d dec=%0d, want %0d %0d",
                     s_wr_cnt - sw0, dec_wr_cnt - dw0, 2 * MSG, MSG);
        end
        tick();
    endtask

    task automatic test_all_a(input bit corrupt_last);
        int cyc;
        int dw0;
        int na;
        set_identity();
        make_ks();
        for (int k = 0; k < MSG; k++) enc_init[k] = ks[k] ^ 8'h61;
        if (corrupt_last) enc_init[MSG-1] = ks[MSG-1] ^ 8'h7B;
        load_mems();
        dw0 = dec_wr_cnt;
        run_wait(1'b0, cyc);
        na = 0;
        for (int k = 0; k < MSG - 1; k++) if (dec_mem[k] !== 8'h61) na++;
        nchk++;
        if (na != 0) begin
            nerr++;
            $display("FAIL all_a_bytes: %0d of first 31 bytes not 61", na);
        end
        nchk++;
        if (dec_mem[MSG-1] !== (corrupt_last ? 8'h7B : 8'h61)) begin
            nerr++;
            $display("FAIL all_a_last: got %h, want %h", dec_mem[MSG-1],
                     corrupt_last ? 8'h7B : 8'h61);
        end
        nchk++;
        if (key_valid !== !corrupt_last || cyc != 9 * MSG + 1) begin
            nerr++;
            $display("FAIL all_a_done: key_valid=%b cyc=%0d, want %b %0d",
                     key_valid, cyc, !corrupt_last, 9 * MSG + 1);
        end
        nchk++;
        if (dec_wr_cnt - dw0 != MSG) begin
            nerr++;
            $display("FAIL all_a_writes: got %0d, want %0d", dec_wr_cnt - dw0, MSG);
        end
        tick();
    endtask

    task automatic test_i_eq_j();
        int n;
        int p;
        logic [7:0] t;
        set_random_perm();
        for (int x = 0; x < 256; x++) if (s_init[x] == 8'd1) p = x;
        t = s_init[1];
        s_init[1] = 8'd1;
        s_init[p] = t;
        for (int k = 0; k < MSG; k++) enc_init[k] = 8'($urandom);
        model_run();
        load_mems();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!dec_wren && n < 20) begin
            tick();
            n++;
        end
        nchk++;
        if (s_mem[1] !== 8'd1 || dec_data !== (s_init[2] ^ enc_init[0])) begin
            nerr++;
            $display("FAIL ieqj_byte0: S[1]=%h dec=%h, want 01 %h",
                     s_mem[1], dec_data, s_init[2] ^ enc_init[0]);
        end
        n = 0;
        while (!done && n < 2000) begin
            tick();
            n++;
        end
        nchk++;
        if (dec_diff() != 0 || key_valid !== m_ok) begin
            nerr++;
            $display("FAIL ieqj_run: %0d bytes differ, key_valid=%b want %b",
                     dec_diff(), key_valid, m_ok);
        end
        tick();
    endtask

    task automatic test_random(input int rounds);
        int cyc;
        for (int r = 0; r < rounds; r++) begin
            set_random_perm();
            make_ks();
            for (int k = 0; k < MSG; k++) begin
                if (r % 2 == 0)
                    enc_init[k] = ks[k] ^ (($urandom_range(3, 0) == 0) ? 8'h20
                                          : 8'(8'h61 + $urandom_range(25, 0)));
                else
                    enc_init[k] = 8'($urandom);
            end
            model_run();
            load_mems();
            run_wait(1'b0, cyc);
            nchk++;
            if (dec_diff() != 0 || s_mem !== m_s) begin
                nerr++;
                $display("FAIL random_%0d: %0d bytes differ or S differs", r, dec_diff());
            end
            nchk++;
            if (key_valid !== m_ok || cyc != 9 * MSG + 1) begin
                nerr++;
                $display("FAIL random_done_%0d: key_valid=%b cyc=%0d, want %b %0d",
                         r, key_valid, cyc, m_ok, 9 * MSG + 1);
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        int n;
        int dw0;
        int sw0;
        int bad;
        int cyc;
        set_identity();
        set_enc_zero();
        load_mems();
        dw0 = dec_wr_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (dec_wr_cnt - dw0 < 10 && n < 500) begin
            tick();
            n++;
        end
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({done, s_address, s_wren, rom_address, dec_wren, dec_address} !== 21'd0) begin
            nerr++;
            $display("FAIL midreset_async: done=%b s_addr=%h rom=%h dec_addr=%h, want 0",
                     done, s_address, rom_address, dec_address);
        end
        sw0 = s_wr_cnt;
        dw0 = dec_wr_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if ({done, key_valid, s_address, s_wren, rom_address, dec_wren} !== 17'd0)
                bad++;
        end
        nchk++;
        if (bad != 0 || s_wr_cnt != sw0 || dec_wr_cnt != dw0) begin
            nerr++;
            $display("FAIL midreset_quiet: bad=%0d s_writes=%0d dec_writes=%0d, want 0",
                     bad, s_wr_cnt - sw0, dec_wr_cnt - dw0);
        end
        load_mems();
        run_wait(1'b0, cyc);
        nchk++;
        if (dec_mem[0] !== 8'h02 || dec_mem[1] !== 8'h05 || key_valid !== 1'b0) begin
            nerr++;
            $display("FAIL midreset_rerun: got %h %h kv=%b, want 02 05 0",
                     dec_mem[0], dec_mem[1], key_valid);
        end
        tick();
    endtask

    task automatic test_start_hold();
        int cyc;
        int dw0;
        int low;
        set_identity();
        set_enc_zero();
        load_mems();
        run_wait(1'b1, cyc);
        dw0 = dec_wr_cnt;
        low = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done !== 1'b1) low++;
        end
        nchk++;
        if (low != 0 || dec_wr_cnt != dw0) begin
            nerr++;
            $display("FAIL hold_no_restart: done low %0d cycles, %0d writes, want 0 0",
                     low, dec_wr_cnt - dw0);
        end
        start = 1'b0;
        tick();
        nchk++;
        if (done !== 1'b0) begin
            nerr++;
            $display("FAIL hold_release: done=%b, want 0", done);
        end
        load_mems();
        start = 1'b1;
        tick();
        start = 1'b0;
        nchk++;
        if (done !== 1'b0 || s_address !== 8'd1) begin
            nerr++;
            $display("FAIL hold_restart: done=%b s_addr=%h, want 0 01", done, s_address);
        end
        cyc = 1;
        while (!done && cyc < 2000) begin
            tick();
            cyc++;
        end
        nchk++;
        if (cyc != 9 * MSG + 1 || dec_mem[0] !== 8'h02) begin
            nerr++;
            $display("FAIL hold_rerun: cyc=%0d dec0=%h, want %0d 02",
                     cyc, dec_mem[0], 9 * MSG + 1);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_identity_zero();
        test_all_a(1'b0);
        test_all_a(1'b1);
        test_i_eq_j();
        test_random(4);
        test_mid_reset();
        test_start_hold();
        nchk++;
        if (bad_idle != 0) begin
            nerr++;
            $display("FAIL data_when_disabled: %0d cycles with nonzero data, want 0",
                     bad_idle);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
